// File: rtl/sram_access_ctrl.sv
// Single-port async SRAM sequencer: one timed read or write per trigger edge.
// All pin outputs are registered from next-state logic, so strobes have no input-to-output path.
module sram_access_ctrl #(
  parameter int ADDR_W    = 16,
  parameter int SETUP_CYC = 1,
  parameter int PULSE_CYC = 2,
  parameter int HOLD_CYC  = 1
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              trig_in,
  input  logic              rw_in,
  input  logic [1:0]        bank_in,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [7:0]        wr_data_in,
  output logic              done_out,
  output logic [7:0]        rd_data_out,
  output logic              rd_valid_out,
  output logic [ADDR_W+1:0] sram_addr_out,
  output logic [7:0]        sram_dq_out,
  output logic              sram_dq_oe,
  input  logic [7:0]        sram_dq_in,
  output logic              sram_ce_n,
  output logic              sram_we_n,
  output logic              sram_oe_n
);

  // state | meaning
  // IDLE  | ready, waiting for a trigger rising edge
  // SETUP | address/CE valid ahead of the strobe
  // PULSE | WE_n or OE_n asserted
  // HOLD  | strobe released, address/data still held
  typedef enum logic [1:0] {IDLE, SETUP, PULSE, HOLD} state_t;

  localparam logic [3:0] SETUP_LD = 4'(SETUP_CYC - 1);
  localparam logic [3:0] PULSE_LD = 4'(PULSE_CYC - 1);
  localparam logic [3:0] HOLD_LD  = 4'(HOLD_CYC - 1);

  state_t            state, state_nxt;
  logic [3:0]        cnt, cnt_nxt;
  logic              trig_d, rw_q, ok_q, rw_nxt, ok_nxt;
  logic [7:0]        rd_cap, rd_cap_nxt, rd_data_nxt, dq_nxt;
  logic [ADDR_W+1:0] addr_nxt;
  logic              rd_valid_nxt, done_nxt, ce_n_nxt, we_n_nxt, oe_n_nxt, dq_oe_nxt;
  logic              cnt_zero;

  assign cnt_zero = (cnt == 4'd0);

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    rw_nxt       = rw_q;
    ok_nxt       = ok_q;
    addr_nxt     = sram_addr_out;
    dq_nxt       = sram_dq_out;
    rd_cap_nxt   = rd_cap;
    rd_data_nxt  = rd_data_out;
    rd_valid_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (trig_in && !trig_d) begin
          state_nxt = SETUP;
          cnt_nxt   = SETUP_LD;
          rw_nxt    = rw_in;
          ok_nxt    = (bank_in != 2'b11);
          addr_nxt  = {bank_in, addr_in};
          dq_nxt    = wr_data_in;
        end
      end
      SETUP: begin
        if (cnt_zero) begin
          state_nxt = PULSE;
          cnt_nxt   = PULSE_LD;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      PULSE: begin
        if (cnt_zero) begin
          state_nxt = HOLD;
          cnt_nxt   = HOLD_LD;
          // invalid bank never enables the pad, so report zero instead of floating data
          if (rw_q) rd_cap_nxt = ok_q ? sram_dq_in : 8'h00;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      HOLD: begin
        if (cnt_zero) begin
          state_nxt = IDLE;
          if (rw_q) begin
            rd_data_nxt  = rd_cap;
            rd_valid_nxt = 1'b1;
          end
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase

    done_nxt  = (state_nxt == IDLE);
    ce_n_nxt  = !(!done_nxt && ok_nxt);
    we_n_nxt  = !((state_nxt == PULSE) && !rw_nxt && ok_nxt);
    oe_n_nxt  = !((state_nxt == PULSE) && rw_nxt && ok_nxt);
    dq_oe_nxt = !done_nxt && !rw_nxt && ok_nxt;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state         <= IDLE;
      cnt           <= 4'd0;
      trig_d        <= 1'b0;
      rw_q          <= 1'b0;
      ok_q          <= 1'b0;
      rd_cap        <= 8'h00;
      done_out      <= 1'b1;
      rd_data_out   <= 8'h00;
      rd_valid_out  <= 1'b0;
      sram_addr_out <= '0;
      sram_dq_out   <= 8'h00;
      sram_dq_oe    <= 1'b0;
      sram_ce_n     <= 1'b1;
      sram_we_n     <= 1'b1;
      sram_oe_n     <= 1'b1;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      trig_d        <= trig_in;
      rw_q          <= rw_nxt;
      ok_q          <= ok_nxt;
      rd_cap        <= rd_cap_nxt;
      done_out      <= done_nxt;
      rd_data_out   <= rd_data_nxt;
      rd_valid_out  <= rd_valid_nxt;
      sram_addr_out <= addr_nxt;
      sram_dq_out   <= dq_nxt;
      sram_dq_oe    <= dq_oe_nxt;
      sram_ce_n     <= ce_n_nxt;
      sram_we_n     <= we_n_nxt;
      sram_oe_n     <= oe_n_nxt;
    end
  end

endmodule

// File: tb/tb_sram_access_ctrl.sv
// Directed bench for sram_access_ctrl: default-timing instance plus a 3/4/2 instance,
// per-cycle pin expectations and a read-data scoreboard.
module tb_sram_access_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        trig = 1'b0;
  logic        rw = 1'b0;
  logic [1:0]  bank = 2'b00;
  logic [15:0] addr = 16'h0;
  logic [7:0]  wdata = 8'h0;
  logic [7:0]  pad = 8'h0;

  logic        a_done, a_rdv, a_oe, a_ce, a_we, a_oen;
  logic [7:0]  a_rd, a_dq;
  logic [17:0] a_addr;
  logic        b_done, b_rdv, b_oe, b_ce, b_we, b_oen;
  logic [7:0]  b_rd, b_dq;
  logic [17:0] b_addr;

  logic        use2 = 1'b0;
  logic        o_done, o_rdv, o_oe, o_ce, o_we, o_oen;
  logic [7:0]  o_rd, o_dq;
  logic [17:0] o_addr;

  int checks = 0;
  int failures = 0;
  logic [7:0] sb[$];

  always #5 clk = ~clk;

  sram_access_ctrl dut (
    .clk_in(clk), .rst_in(rst_n), .trig_in(trig), .rw_in(rw), .bank_in(bank),
    .addr_in(addr), .wr_data_in(wdata), .done_out(a_done), .rd_data_out(a_rd),
    .rd_valid_out(a_rdv), .sram_addr_out(a_addr), .sram_dq_out(a_dq),
    .sram_dq_oe(a_oe), .sram_dq_in(pad), .sram_ce_n(a_ce), .sram_we_n(a_we),
    .sram_oe_n(a_oen));

  sram_access_ctrl #(.SETUP_CYC(3), .PULSE_CYC(4), .HOLD_CYC(2)) dut2 (
    .clk_in(clk), .rst_in(rst_n), .trig_in(trig), .rw_in(rw), .bank_in(bank),
    .addr_in(addr), .wr_data_in(wdata), .done_out(b_done), .rd_data_out(b_rd),
    .rd_valid_out(b_rdv), .sram_addr_out(b_addr), .sram_dq_out(b_dq),
    .sram_dq_oe(b_oe), .sram_dq_in(pad), .sram_ce_n(b_ce), .sram_we_n(b_we),
    .sram_oe_n(b_oen));

  always_comb begin
    o_done = use2 ? b_done : a_done;
    o_rdv  = use2 ? b_rdv  : a_rdv;
    o_oe   = use2 ? b_oe   : a_oe;
    o_ce   = use2 ? b_ce   : a_ce;
    o_we   = use2 ? b_we   : a_we;
    o_oen  = use2 ? b_oen  : a_oen;
    o_rd   = use2 ? b_rd   : a_rd;
    o_dq   = use2 ? b_dq   : a_dq;
    o_addr = use2 ? b_addr : a_addr;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // mode 0: trigger dropped after start; 1: held high ~10 cycles; 2: extra edge mid-access
  task automatic run_access(input logic r, input logic [1:0] b, input logic [15:0] a,
                            input logic [7:0] d, input logic [7:0] p,
                            input int s, input int pw, input int h, input int mode);
    int  busy_n;
    logic ok, busy, strobe;
    logic [7:0] exp_rd;
    busy_n = s + pw + h;
    ok = (b != 2'b11);
    @(negedge clk);
    trig = 1'b1; rw = r; bank = b; addr = a; wdata = d; pad = p;
    if (r) sb.push_back(ok ? p : 8'h00);
    for (int k = 1; k <= busy_n + 6; k++) begin
      @(negedge clk);
      busy   = (k <= busy_n);
      strobe = (k > s) && (k <= s + pw);
      check($sformatf("done k=%0d", k), o_done, !busy);
      check($sformatf("ce_n k=%0d", k), o_ce, !(busy && ok));
      check($sformatf("we_n k=%0d", k), o_we, !(strobe && !r && ok));
      check($sformatf("oe_n k=%0d", k), o_oen, !(strobe && r && ok));
      check($sformatf("dq_oe k=%0d", k), o_oe, busy && !r && ok);
      check($sformatf("addr k=%0d", k), o_addr, {b, a});
      if (busy && !r && ok) check($sformatf("dq_out k=%0d", k), o_dq, d);
      check($sformatf("rd_valid k=%0d", k), o_rdv, r && (k == busy_n + 1));
      if (o_rdv) begin
        if (sb.size() == 0) check("sb_underflow", 32'd1, 32'd0);
        else begin
          exp_rd = sb.pop_front();
          check($sformatf("rd_data k=%0d", k), o_rd, exp_rd);
        end
      end
      // later input changes must not disturb the access in flight
      addr = ~a; wdata = ~d; bank = ~b; rw = ~r;
      case (mode)
        1:       trig = (k < 9);
        2:       trig = (k == 2);
        default: trig = 1'b0;
      endcase
    end
    trig = 1'b0;
  endtask

  initial begin
    #12;
    check("rst done", a_done, 1'b1);
    check("rst ce_n", a_ce, 1'b1);
    check("rst we_n", a_we, 1'b1);
    check("rst oe_n", a_oen, 1'b1);
    check("rst dq_oe", a_oe, 1'b0);
    check("rst addr", a_addr, 18'h0);
    check("rst dq_out", a_dq, 8'h0);
    check("rst rd_data", a_rd, 8'h0);
    check("rst rd_valid", a_rdv, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_access(1'b0, 2'b01, 16'h0123, 8'hA5, 8'h00, 1, 2, 1, 0);
    run_access(1'b1, 2'b10, 16'h0040, 8'h00, 8'h3C, 1, 2, 1, 0);
    run_access(1'b1, 2'b00, 16'h0007, 8'h00, 8'h5A, 1, 2, 1, 1);
    run_access(1'b0, 2'b00, 16'h0FFF, 8'h81, 8'h00, 1, 2, 1, 2);
    run_access(1'b1, 2'b11, 16'h1234, 8'h00, 8'hFF, 1, 2, 1, 0);

    // reset asserted while the write strobe is low
    @(negedge clk);
    trig = 1'b1; rw = 1'b0; bank = 2'b01; addr = 16'h0200; wdata = 8'h33;
    @(negedge clk);
    trig = 1'b0;
    @(negedge clk);
    check("pre-rst we_n", a_we, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("async we_n", a_we, 1'b1);
    check("async ce_n", a_ce, 1'b1);
    check("async done", a_done, 1'b1);
    check("async dq_oe", a_oe, 1'b0);
    check("async addr", a_addr, 18'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_access(1'b0, 2'b01, 16'h0321, 8'h5C, 8'h00, 1, 2, 1, 0);

    use2 = 1'b1;
    run_access(1'b0, 2'b10, 16'hBEEF, 8'hC3, 8'h00, 3, 4, 2, 0);
    run_access(1'b1, 2'b01, 16'h00AA, 8'h00, 8'h96, 3, 4, 2, 0);

    check("sb empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
